// File: rtl/prog_loader_if.sv
// Bus between the program source (master) and the bit-serial loader (slave).
// Carries the serial input stream, the program RAM write port and the status flags.
interface prog_loader_if #(
    parameter int AW = 4,
    parameter int IW = 9
);
    logic          load_req;
    logic          bit_valid;
    logic          sdata;
    logic          wr_en;
    logic [AW-1:0] WR_ADDR;
    logic [IW-1:0] WR_DATA;
    logic          set_pc;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output load_req, bit_valid, sdata,
        input  wr_en, WR_ADDR, WR_DATA, set_pc, busy, done, err
    );

    modport slave (
        input  load_req, bit_valid, sdata,
        output wr_en, WR_ADDR, WR_DATA, set_pc, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Bit-serial program loader: deserialises MSB-first instruction words, writes
// them into program RAM at consecutive addresses, then checks a trailing XOR
// checksum word. set_pc holds the CPU at PC 0 for the whole frame.
module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    localparam int BCW = (IW > 1) ? $clog2(IW) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [BCW-1:0] BC_LAST = BCW'(IW - 1);
    localparam logic [AW:0]    WC_FULL = (AW + 1)'(DEPTH);

    logic [2:0]     state_q,   state_d;
    logic [IW-1:0]  sr_q,      sr_d;
    logic [BCW-1:0] bc_q,      bc_d;
    logic [AW:0]    wc_q,      wc_d;
    logic [IW-1:0]  ck_q,      ck_d;
    logic           err_q,     err_d;
    logic           wr_en_q,   wr_en_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [IW-1:0]  wr_data_q, wr_data_d;
    logic           set_pc_q,  set_pc_d;
    logic           busy_q,    busy_d;
    logic           done_q,    done_d;
    logic [IW-1:0]  shifted;

    // Next-state logic: a word's write strobe and address/data are prepared on the
    // edge that takes its last bit, so wr_en is high exactly during WRITE; a
    // load_req overrides everything and (re)starts the frame.
    always_comb begin
        shifted   = {sr_q[IW-2:0], bus.sdata};
        state_d   = state_q;
        sr_d      = sr_q;
        bc_d      = bc_q;
        wc_d      = wc_q;
        ck_d      = ck_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        set_pc_d  = set_pc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_SHIFT: begin
                if (bus.bit_valid) begin
                    sr_d = shifted;
                    if (bc_q == BC_LAST) begin
                        bc_d = '0;
                        if (wc_q < WC_FULL) begin
                            state_d   = S_WRITE;
                            wr_en_d   = 1'b1;
                            wr_addr_d = wc_q[AW-1:0];
                            wr_data_d = shifted;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        bc_d = bc_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                ck_d    = ck_q ^ sr_q;
                wc_d    = wc_q + 1'b1;
                state_d = S_SHIFT;
                if (bus.bit_valid) begin
                    sr_d = shifted;
                    bc_d = bc_q + 1'b1;
                end
            end
            S_CHECK: begin
                err_d   = (sr_q != ck_q);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                set_pc_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.load_req) begin
            state_d  = S_SHIFT;
            sr_d     = '0;
            bc_d     = '0;
            wc_d     = '0;
            ck_d     = '0;
            err_d    = 1'b0;
            wr_en_d  = 1'b0;
            done_d   = 1'b0;
            set_pc_d = 1'b1;
            busy_d   = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bc_q      <= '0;
            wc_q      <= '0;
            ck_q      <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            set_pc_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bc_q      <= bc_d;
            wc_q      <= wc_d;
            ck_q      <= ck_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            set_pc_q  <= set_pc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.WR_ADDR = wr_addr_q;
    assign bus.WR_DATA = wr_data_q;
    assign bus.set_pc  = set_pc_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule
